// File: rtl/ram_pkg.sv
// Shared types and helpers for the masked multi-read RAM: address width calc,
// clear/ready state encoding and byte-lane merge used by write-first forwarding.
package ram_pkg;

    // Widest word/mask the lane-merge helper handles; callers cast in and out.
    localparam int MERGE_W = 512;

    typedef enum logic {
        CLEAR,
        READY
    } ram_state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    function automatic logic [MERGE_W-1:0] merge_lanes(
        input logic [MERGE_W-1:0] old_word,
        input logic [MERGE_W-1:0] new_word,
        input logic [MERGE_W-1:0] mask,
        input int                 lane_w
    );
        logic [MERGE_W-1:0] r;
        for (int b = 0; b < MERGE_W; b++) begin
            r[b] = mask[b / lane_w] ? new_word[b] : old_word[b];
        end
        return r;
    endfunction

endpackage

// File: rtl/ram_rd_port.sv
// One registered read port: range check, optional same-cycle write forwarding
// (RAM_WRITE_BYPASS_EN) and the output data/valid registers.
module ram_rd_port
    import ram_pkg::*;
#(
    parameter int WORD_COUNT = 256,
    parameter int WORD_WIDTH = 32,
    parameter int MASK_WIDTH = 4,
    parameter int AW         = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ready,
    input  logic                  rd_en,
    input  logic [AW-1:0]         rd_addr,
    input  logic [WORD_WIDTH-1:0] mem_word,
`ifdef RAM_WRITE_BYPASS_EN
    input  logic                  wr_en,
    input  logic [MASK_WIDTH-1:0] wr_mask,
    input  logic [AW-1:0]         wr_addr,
    input  logic [WORD_WIDTH-1:0] wr_data,
`endif
    output logic [WORD_WIDTH-1:0] rd_data,
    output logic                  rd_valid
);

    logic                  in_range;
    logic                  rd_fire;
    logic [WORD_WIDTH-1:0] rd_next;
    logic [WORD_WIDTH-1:0] data_p1;
    logic                  vld_p1;

    assign in_range = 32'(rd_addr) < WORD_COUNT;
    assign rd_fire  = rd_en && ready;

`ifdef RAM_WRITE_BYPASS_EN
    logic wr_hit;
    assign wr_hit = ready && wr_en && (wr_addr == rd_addr);

    // Write-first: masked lanes come from the incoming write, the rest from the array.
    always_comb begin
        rd_next = '0;
        if (in_range) begin
            if (wr_hit) begin
                rd_next = WORD_WIDTH'(merge_lanes(MERGE_W'(mem_word), MERGE_W'(wr_data),
                                                  MERGE_W'(wr_mask), WORD_WIDTH / MASK_WIDTH));
            end else begin
                rd_next = mem_word;
            end
        end
    end
`else
    always_comb begin
        rd_next = '0;
        if (in_range) begin
            rd_next = mem_word;
        end
    end
`endif

    // ---- stage p1: registered read data ----
    always_ff @(posedge clk) begin
        if (reset) begin
            data_p1 <= '0;
            vld_p1  <= 1'b0;
        end else begin
            vld_p1 <= rd_fire;
            if (rd_fire) begin
                data_p1 <= rd_next;
            end
        end
    end

    assign rd_data  = data_p1;
    assign rd_valid = vld_p1;

endmodule

// File: rtl/ram_1w_nr_masked.sv
// Single-write, multi-read RAM with byte-lane masks and post-reset clear sequencer.
// Define RAM_WRITE_BYPASS_EN for write-first read-under-write; default is read-first.
module ram_1w_nr_masked
    import ram_pkg::*;
#(
    parameter int WORD_COUNT     = 256,
    parameter int WORD_WIDTH     = 32,
    parameter int MASK_WIDTH     = 4,
    parameter int READ_PORTS     = 2,
    parameter int CLEAR_ON_RESET = 1,
    localparam int AW            = ram_pkg::clog2(WORD_COUNT),
    localparam int LW            = WORD_WIDTH / MASK_WIDTH
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             wr_en,
    input  logic [MASK_WIDTH-1:0]            wr_mask,
    input  logic [AW-1:0]                    wr_addr,
    input  logic [WORD_WIDTH-1:0]            wr_data,
    input  logic [READ_PORTS-1:0]            rd_en,
    input  logic [READ_PORTS*AW-1:0]         rd_addr,
    output logic [READ_PORTS*WORD_WIDTH-1:0] rd_data,
    output logic [READ_PORTS-1:0]            rd_valid,
    output logic                             init_busy
);

    ram_state_t            state;
    logic [AW-1:0]         clr_addr;
    logic                  ready;
    logic                  wr_in_range;
    logic [WORD_WIDTH-1:0] mem [WORD_COUNT];

    assign ready       = (state == READY);
    assign init_busy   = (state == CLEAR);
    assign wr_in_range = 32'(wr_addr) < WORD_COUNT;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
            clr_addr <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    clr_addr <= clr_addr + AW'(1);
                    if (clr_addr == AW'(WORD_COUNT - 1)) begin
                        state <= READY;
                    end
                end
                default: state <= READY;
            endcase
        end
    end

    // The array itself is never reset; the sequencer owns it while clearing,
    // and user writes are simply dropped until then.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (init_busy) begin
                mem[clr_addr] <= '0;
            end else if (wr_en && wr_in_range) begin
                for (int i = 0; i < MASK_WIDTH; i++) begin
                    if (wr_mask[i]) begin
                        mem[wr_addr][i*LW +: LW] <= wr_data[i*LW +: LW];
                    end
                end
            end
        end
    end

    for (genvar p = 0; p < READ_PORTS; p++) begin : g_rd
        logic [AW-1:0] addr_p;
        assign addr_p = rd_addr[p*AW +: AW];

        ram_rd_port #(
            .WORD_COUNT(WORD_COUNT),
            .WORD_WIDTH(WORD_WIDTH),
            .MASK_WIDTH(MASK_WIDTH),
            .AW        (AW)
        ) u_port (
            .clk      (clk),
            .reset    (reset),
            .ready    (ready),
            .rd_en    (rd_en[p]),
            .rd_addr  (addr_p),
            .mem_word (mem[addr_p]),
`ifdef RAM_WRITE_BYPASS_EN
            .wr_en    (wr_en),
            .wr_mask  (wr_mask),
            .wr_addr  (wr_addr),
            .wr_data  (wr_data),
`endif
            .rd_data  (rd_data[p*WORD_WIDTH +: WORD_WIDTH]),
            .rd_valid (rd_valid[p])
        );
    end

endmodule
